// File: rtl/winograd_tile_collector_pkg.sv
// Shared types and constants for the Winograd output-tile collector.
package winograd_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int TILE_SIZE  = 4;
  localparam int GRID_ROWS  = 3;
  localparam int GRID_COLS  = 3;

  typedef logic [0:TILE_SIZE-1][0:TILE_SIZE-1][DATA_WIDTH-1:0] tile_t;
  typedef tile_t [0:GRID_ROWS-1][0:GRID_COLS-1] tile_grid_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } collect_state_e;

  function automatic logic cfg_legal(input logic [1:0] rows, input logic [1:0] cols);
    return (rows != 2'd0) && (cols != 2'd0) &&
           (int'(rows) <= GRID_ROWS) && (int'(cols) <= GRID_COLS);
  endfunction
endpackage

// File: rtl/winograd_tile_collector_if.sv
// Tile stream and frame handoff between inverse transform, collector and stitcher.
interface winograd_tile_collector_if;
  import winograd_pkg::*;

  logic       tile_valid;
  logic       tile_ready;
  tile_t      tile_in;
  logic [1:0] tile_row;
  logic [1:0] tile_col;
  logic       frame_valid;
  logic       frame_ready;
  tile_grid_t tiles;

  modport master (
    output tile_valid, tile_in, frame_ready,
    input  tile_ready, tile_row, tile_col, frame_valid, tiles
  );

  modport slave (
    input  tile_valid, tile_in, frame_ready,
    output tile_ready, tile_row, tile_col, frame_valid, tiles
  );
endinterface

// File: rtl/winograd_tile_collector_counter.sv
// Raster row/col counter over a configurable grid; wraps to 0,0 after the last slot.
module tile_raster_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  input  logic [1:0] rows_lim,
  input  logic [1:0] cols_lim,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       last
);
  logic col_end;
  logic row_end;

  assign col_end = (col == cols_lim - 2'd1);
  assign row_end = (row == rows_lim - 2'd1);
  assign last    = col_end & row_end;

  // Wrapping after the last slot keeps both counters within the 3x3 grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 2'd0;
      col <= 2'd0;
    end else if (clear) begin
      row <= 2'd0;
      col <= 2'd0;
    end else if (inc) begin
      if (col_end) begin
        col <= 2'd0;
        row <= row_end ? 2'd0 : row + 2'd1;
      end else begin
        col <= col + 2'd1;
      end
    end
  end
endmodule

// File: rtl/winograd_tile_collector.sv
// Collects raster-ordered 4x4 output tiles into a 3x3 buffer and hands it off as a frame.
// state   | meaning
// IDLE    | waiting for start; buffer holds the last frame
// COLLECT | accepting tiles into the configured grid
// FULL    | frame presented downstream until frame_ready
module winograd_tile_collector
  import winograd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                cfg_rows,
  input  logic [1:0]                cfg_cols,
  output logic                      cfg_error,
  output logic                      busy,
  winograd_tile_collector_if.slave  bus
);
  collect_state_e state_q;
  collect_state_e state_d;
  logic [1:0]     rows_q;
  logic [1:0]     cols_q;
  tile_grid_t     tiles_q;
  logic [1:0]     row;
  logic [1:0]     col;
  logic           last;
  logic           tile_ready_c;
  logic           frame_valid_c;
  logic           busy_c;
  logic           start_ok;
  logic           start_bad;
  logic           accept;

  assign start_ok  = (state_q == IDLE) && start && cfg_legal(cfg_rows, cfg_cols);
  assign start_bad = (state_q == IDLE) && start && !cfg_legal(cfg_rows, cfg_cols);
  assign accept    = bus.tile_valid && tile_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = COLLECT;
      COLLECT: if (accept && last) state_d = FULL;
      FULL:    if (bus.frame_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tile_ready_c  = 1'b0;
    frame_valid_c = 1'b0;
    busy_c        = 1'b0;
    case (state_q)
      COLLECT: begin
        tile_ready_c = 1'b1;
        busy_c       = 1'b1;
      end
      FULL: begin
        frame_valid_c = 1'b1;
        busy_c        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q    <= 2'd0;
      cols_q    <= 2'd0;
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= start_bad;
      if (start_ok) begin
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
      end
    end
  end

  // Zeroing on start guarantees slots outside the configured grid read back as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tiles_q <= '0;
    else if (start_ok) tiles_q <= '0;
    else if (accept)   tiles_q[row][col] <= bus.tile_in;
  end

  tile_raster_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .inc      (accept),
    .rows_lim (rows_q),
    .cols_lim (cols_q),
    .row      (row),
    .col      (col),
    .last     (last)
  );

  assign bus.tile_ready  = tile_ready_c;
  assign bus.frame_valid = frame_valid_c;
  assign bus.tile_row    = row;
  assign bus.tile_col    = col;
  assign bus.tiles       = tiles_q;
  assign busy            = busy_c;
endmodule

// File: tb/tb_winograd_tile_collector.sv
// Directed bench for winograd_tile_collector with hand-computed expected tiles.
module tb_winograd_tile_collector;
  import winograd_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cfg_rows;
  logic [1:0] cfg_cols;
  logic       cfg_error;
  logic       busy;
  int         checks;
  int         errors;
  tile_grid_t exp_grid;

  winograd_tile_collector_if bus ();

  winograd_tile_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .cfg_error (cfg_error),
    .busy      (busy),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tile_t mk_tile(input int k);
    tile_t t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[i][j] = 16'(16 * k + 4 * i + j);
    return t;
  endfunction

  function automatic tile_t fill_tile(input logic [15:0] v);
    tile_t t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        t[i][j] = v;
    return t;
  endfunction

  function automatic int diff_idx(input tile_grid_t a, input tile_grid_t b);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (a[r][c] !== b[r][c]) return 3 * r + c;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic report_tiles(input string name);
    int d;
    d = diff_idx(bus.tiles, exp_grid);
    $display("FAIL %s: tile[%0d][%0d] got %h expected %h", name, d / 3, d % 3,
             bus.tiles[d / 3][d % 3], exp_grid[d / 3][d % 3]);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, bus.tile_ready, bus.frame_valid, cfg_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/ready/fvalid/cfgerr got %b expected 0000",
               {busy, bus.tile_ready, bus.frame_valid, cfg_error});
    end
    checks++;
    if ({bus.tile_row, bus.tile_col} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rowcol: got %b expected 0000", {bus.tile_row, bus.tile_col});
    end
    exp_grid = '0;
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("reset_tiles"); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    start = 1'b1; cfg_rows = 2'd2; cfg_cols = 2'd3;
    step();
    start = 1'b0;
    checks++;
    if ({busy, bus.tile_ready, bus.frame_valid} !== 3'b110) begin
      errors++;
      $display("FAIL normal_enter: busy/ready/fvalid got %b expected 110",
               {busy, bus.tile_ready, bus.frame_valid});
    end
    exp_grid = '0;
    for (int k = 0; k < 6; k++) begin
      bus.tile_valid = 1'b1;
      bus.tile_in    = mk_tile(k);
      exp_grid[k / 3][k % 3] = mk_tile(k);
      checks++;
      if (bus.tile_row !== 2'(k / 3) || bus.tile_col !== 2'(k % 3) || bus.frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL normal_pos%0d: row/col/fvalid got %0d/%0d/%b expected %0d/%0d/0",
                 k, bus.tile_row, bus.tile_col, bus.frame_valid, k / 3, k % 3);
      end
      step();
    end
    bus.tile_valid = 1'b0;
    checks++;
    if ({bus.frame_valid, bus.tile_ready} !== 2'b10) begin
      errors++;
      $display("FAIL normal_full: fvalid/ready got %b expected 10", {bus.frame_valid, bus.tile_ready});
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("normal_tiles"); end
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
    checks++;
    if ({busy, bus.frame_valid} !== 2'b00) begin
      errors++;
      $display("FAIL normal_release: busy/fvalid got %b expected 00", {busy, bus.frame_valid});
    end
  endtask

  task automatic test_bubbles();
    int n;
    int cyc;
    start = 1'b1; cfg_rows = 2'd3; cfg_cols = 2'd3;
    step();
    start = 1'b0;
    exp_grid = '0;
    n = 0;
    cyc = 0;
    while (n < 9 && cyc < 60) begin
      if (cyc % 3 == 0) begin
        bus.tile_valid = 1'b1;
        bus.tile_in    = mk_tile(8 + n);
        exp_grid[n / 3][n % 3] = mk_tile(8 + n);
        checks++;
        if (bus.tile_ready !== 1'b1 || bus.tile_row !== 2'(n / 3) || bus.tile_col !== 2'(n % 3)) begin
          errors++;
          $display("FAIL bubbles_pos%0d: ready/row/col got %b/%0d/%0d expected 1/%0d/%0d",
                   n, bus.tile_ready, bus.tile_row, bus.tile_col, n / 3, n % 3);
        end
        n++;
      end else begin
        bus.tile_valid = 1'b0;
        bus.tile_in    = fill_tile(16'hAAAA);
      end
      step();
      cyc++;
    end
    bus.tile_valid = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL bubbles_full: fvalid got %b expected 1", bus.frame_valid);
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("bubbles_tiles"); end
  endtask

  task automatic test_backpressure();
    bus.tile_valid  = 1'b1;
    bus.tile_in     = fill_tile(16'hFFFF);
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.tile_ready, bus.frame_valid} !== 2'b01) begin
        errors++;
        $display("FAIL backpressure_c%0d: ready/fvalid got %b expected 01",
                 i, {bus.tile_ready, bus.frame_valid});
      end
      step();
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("backpressure_tiles"); end
    bus.tile_valid  = 1'b0;
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: busy got %b expected 0", busy);
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("held_after_release"); end
  endtask

  task automatic test_illegal();
    logic [1:0] rv [2];
    logic [1:0] cv [2];
    rv[0] = 2'd0; cv[0] = 2'd2;
    rv[1] = 2'd2; cv[1] = 2'd0;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; cfg_rows = rv[i]; cfg_cols = cv[i];
      step();
      start = 1'b0;
      checks++;
      if ({cfg_error, busy, bus.tile_ready} !== 3'b100) begin
        errors++;
        $display("FAIL illegal%0d_pulse: cfgerr/busy/ready got %b expected 100",
                 i, {cfg_error, busy, bus.tile_ready});
      end
      step();
      checks++;
      if ({cfg_error, busy} !== 2'b00) begin
        errors++;
        $display("FAIL illegal%0d_after: cfgerr/busy got %b expected 00", i, {cfg_error, busy});
      end
      checks++;
      if (bus.tiles !== exp_grid) begin errors++; report_tiles("illegal_tiles"); end
    end
  endtask

  task automatic test_start_busy();
    start = 1'b1; cfg_rows = 2'd2; cfg_cols = 2'd2;
    step();
    start = 1'b0;
    exp_grid = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        bus.tile_valid = 1'b0;
        start = 1'b1; cfg_rows = 2'd3; cfg_cols = 2'd3;
        step();
        start = 1'b0;
        checks++;
        if ({cfg_error, busy, bus.tile_row, bus.tile_col} !== 6'b01_01_00) begin
          errors++;
          $display("FAIL startbusy_ignored: cfgerr/busy/row/col got %b/%b/%0d/%0d expected 0/1/1/0",
                   cfg_error, busy, bus.tile_row, bus.tile_col);
        end
      end
      bus.tile_valid = 1'b1;
      bus.tile_in    = mk_tile(20 + k);
      exp_grid[k / 2][k % 2] = mk_tile(20 + k);
      step();
    end
    bus.tile_valid = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL startbusy_full: fvalid got %b expected 1", bus.frame_valid);
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("startbusy_tiles"); end
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; cfg_rows = 2'd2; cfg_cols = 2'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.tile_valid = 1'b1;
      bus.tile_in    = mk_tile(40 + k);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    exp_grid = '0;
    checks++;
    if ({busy, bus.tile_ready, bus.frame_valid, cfg_error, bus.tile_row, bus.tile_col} !== 8'b0) begin
      errors++;
      $display("FAIL midreset_outputs: busy/ready/fvalid/cfgerr/row/col got %b expected 0",
               {busy, bus.tile_ready, bus.frame_valid, cfg_error, bus.tile_row, bus.tile_col});
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("midreset_tiles"); end
    #2;
    rst_n = 1'b1;
    bus.tile_valid = 1'b0;
    step();
    start = 1'b1; cfg_rows = 2'd1; cfg_cols = 2'd1;
    step();
    start = 1'b0;
    bus.tile_valid = 1'b1;
    bus.tile_in    = fill_tile(16'h1234);
    step();
    bus.tile_valid = 1'b0;
    exp_grid[0][0] = fill_tile(16'h1234);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_full: fvalid got %b expected 1", bus.frame_valid);
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("after_reset_tiles"); end
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; cfg_rows = 2'd1; cfg_cols = 2'd2;
    step();
    start = 1'b0;
    checks++;
    if ({busy, bus.tiles} !== {1'b1, 2304'b0}) begin
      errors++;
      $display("FAIL b2b_start: busy got %b expected 1 with cleared buffer", busy);
    end
    exp_grid = '0;
    for (int k = 0; k < 2; k++) begin
      bus.tile_valid = 1'b1;
      bus.tile_in    = mk_tile(60 + k);
      exp_grid[0][k] = mk_tile(60 + k);
      step();
    end
    bus.tile_valid = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: fvalid got %b expected 1", bus.frame_valid);
    end
    checks++;
    if (bus.tiles !== exp_grid) begin errors++; report_tiles("b2b_tiles"); end
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    start           = 1'b0;
    cfg_rows        = 2'd0;
    cfg_cols        = 2'd0;
    bus.tile_valid  = 1'b0;
    bus.tile_in     = '0;
    bus.frame_ready = 1'b0;
    test_reset();
    test_normal();
    test_bubbles();
    test_backpressure();
    test_illegal();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
